// File: rtl/trigger_sequencer_gen2.sv
// Multi-step trigger sequencer: fires one O_trigger pulse when the configured
// input lines hit in order, each within its min/max inter-trigger window.
module trigger_sequencer_gen2 #(
  parameter  int pNUM_INPUTS    = 4,
  parameter  int pMAX_STEPS     = 8,
  parameter  int pCOUNTER_WIDTH = 16,
  localparam int SRCW  = (pNUM_INPUTS > 1) ? $clog2(pNUM_INPUTS) : 1,
  localparam int STEPW = $clog2(pMAX_STEPS)
) (
  input  logic                                    adc_clk,
  input  logic                                    reset,
  input  logic                                    armed_and_ready,
  input  logic                                    I_bypass,
  input  logic [pNUM_INPUTS-1:0]                  I_trigger,
  input  logic [pMAX_STEPS*SRCW-1:0]              I_step_source,
  input  logic [(pMAX_STEPS-1)*pCOUNTER_WIDTH-1:0] I_min_wait,
  input  logic [(pMAX_STEPS-1)*pCOUNTER_WIDTH-1:0] I_max_wait,
  input  logic [STEPW-1:0]                        I_last_step,
  input  logic                                    I_edge_mode,
  input  logic                                    I_rearm,
  input  logic                                    I_clear_status,
  output logic                                    O_trigger,
  output logic [STEPW-1:0]                        O_step,
  output logic                                    O_too_early,
  output logic                                    O_too_late,
  output logic [1:0]                              state_dbg,
  output logic [pCOUNTER_WIDTH-1:0]               counter_dbg
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    WAIT_NEXT  = 2'd2,
    DONE       = 2'd3
  } state_t;

  localparam logic [STEPW-1:0]          LAST_MAX = STEPW'(pMAX_STEPS - 1);
  localparam logic [STEPW-1:0]          STEP_ONE = STEPW'(1);
  localparam logic [pCOUNTER_WIDTH-1:0] CNT_ONE  = pCOUNTER_WIDTH'(1);

  state_t                    state;
  logic [STEPW-1:0]          step;
  logic [pCOUNTER_WIDTH-1:0] counter;
  logic [pNUM_INPUTS-1:0]    trig_hist;
  logic                      trig_q;
  logic                      too_early;
  logic                      too_late;

  // Window arrays carry one spare entry so step-1 never indexes past the end.
  logic [SRCW-1:0]           cfg_src [pMAX_STEPS];
  logic [pCOUNTER_WIDTH-1:0] cfg_min [pMAX_STEPS];
  logic [pCOUNTER_WIDTH-1:0] cfg_max [pMAX_STEPS];
  logic [STEPW-1:0]          cfg_last;

  logic [SRCW-1:0]           cur_src;
  logic [STEPW-1:0]          step_m1;
  logic [pCOUNTER_WIDTH-1:0] cur_min;
  logic [pCOUNTER_WIDTH-1:0] cur_max;
  logic [STEPW-1:0]          last_clamped;
  logic                      hit;

  always_comb begin
    cur_src      = cfg_src[step];
    step_m1      = step - STEP_ONE;
    cur_min      = cfg_min[step_m1];
    cur_max      = cfg_max[step_m1];
    last_clamped = (I_last_step > LAST_MAX) ? LAST_MAX : I_last_step;
    hit          = I_edge_mode ? (I_trigger[cur_src] & ~trig_hist[cur_src])
                               : I_trigger[cur_src];
  end

  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      step      <= '0;
      counter   <= '0;
      trig_hist <= '0;
      trig_q    <= 1'b0;
      too_early <= 1'b0;
      too_late  <= 1'b0;
      cfg_last  <= '0;
      for (int k = 0; k < pMAX_STEPS; k++) begin
        cfg_src[k] <= '0;
        cfg_min[k] <= '0;
        cfg_max[k] <= '0;
      end
    end else begin
      trig_hist <= I_trigger;
      trig_q    <= 1'b0;
      // Clear first so a same-cycle set below overrides it.
      if (I_clear_status) begin
        too_early <= 1'b0;
        too_late  <= 1'b0;
      end
      if (!armed_and_ready) begin
        state   <= IDLE;
        step    <= '0;
        counter <= '0;
      end else begin
        case (state)
          IDLE: begin
            state    <= WAIT_FIRST;
            step     <= '0;
            counter  <= '0;
            cfg_last <= last_clamped;
            for (int k = 0; k < pMAX_STEPS; k++)
              cfg_src[k] <= I_step_source[k*SRCW +: SRCW];
            for (int k = 0; k < pMAX_STEPS-1; k++) begin
              cfg_min[k] <= I_min_wait[k*pCOUNTER_WIDTH +: pCOUNTER_WIDTH];
              cfg_max[k] <= I_max_wait[k*pCOUNTER_WIDTH +: pCOUNTER_WIDTH];
            end
          end
          WAIT_FIRST: begin
            if (hit) begin
              counter <= '0;
              if (cfg_last == '0) begin
                state  <= DONE;
                trig_q <= 1'b1;
              end else begin
                state <= WAIT_NEXT;
                step  <= STEP_ONE;
              end
            end
          end
          WAIT_NEXT: begin
            if (hit) begin
              if (counter < cur_min) begin
                too_early <= 1'b1;
                state     <= IDLE;
                step      <= '0;
                counter   <= '0;
              end else if (step == cfg_last) begin
                state  <= DONE;
                trig_q <= 1'b1;
              end else begin
                counter <= '0;
                step    <= step + STEP_ONE;
              end
            end else if ((cur_max != '0) && (counter == cur_max)) begin
              too_late <= 1'b1;
              state    <= IDLE;
              step     <= '0;
              counter  <= '0;
            end else if (counter != '1) begin
              counter <= counter + CNT_ONE;
            end
          end
          DONE: begin
            if (I_rearm) begin
              state   <= IDLE;
              step    <= '0;
              counter <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign O_trigger   = I_bypass ? I_trigger[I_step_source[SRCW-1:0]] : trig_q;
  assign O_step      = step;
  assign O_too_early = too_early;
  assign O_too_late  = too_late;
  assign state_dbg   = state;
  assign counter_dbg = counter;

endmodule

// File: doc/trigger_sequencer_gen2.md
TRIGGER_SEQUENCER_GEN2 -- requirements
Module: trigger_sequencer_gen2

Interface
REQ-001 SHALL have parameter pNUM_INPUTS, default 4, number of trigger input lines.
REQ-002 SHALL have parameter pMAX_STEPS, default 8, maximum sequence length (2..16).
REQ-003 SHALL have parameter pCOUNTER_WIDTH, default 16, inter-trigger counter width.
REQ-004 SHALL derive SRCW = clog2(pNUM_INPUTS) (min 1) and STEPW = clog2(pMAX_STEPS).
REQ-005 SHALL use one clock and an asynchronous, active-high reset: adc_clk and reset, declared first.
REQ-006 adc_clk  in  1  sole clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 armed_and_ready  in  1  high = sequencer enabled.
REQ-009 I_bypass  in  1  high = O_trigger follows the step-0 source directly.
REQ-010 I_trigger  in  pNUM_INPUTS  raw trigger lines, synchronous to adc_clk.
REQ-011 I_step_source  in  pMAX_STEPS*SRCW  input index per step; step k at [k*SRCW +: SRCW].
REQ-012 I_min_wait / I_max_wait  in  (pMAX_STEPS-1)*pCOUNTER_WIDTH each  window for step k+1 at [k*W +: W].
REQ-013 I_last_step  in  STEPW  index of the final step.
REQ-014 I_edge_mode  in  1  1 = rising edges, 0 = levels.
REQ-015 I_rearm  in  1  1 = restart after firing; 0 = one-shot per arm.
REQ-016 I_clear_status  in  1  clears sticky status flags.
REQ-017 O_trigger  out  1  sequence-complete pulse.
REQ-018 O_step  out  STEPW  step currently awaited.
REQ-019 O_too_early / O_too_late  out  1 each  sticky abort flags.

Function
REQ-020 States SHALL be IDLE, WAIT_FIRST, WAIT_NEXT, DONE.
REQ-021 IDLE->WAIT_FIRST when armed_and_ready; I_step_source, I_min_wait, I_max_wait, I_last_step SHALL be latched on that transition and held until the next return to IDLE.
REQ-022 Latched I_last_step > pMAX_STEPS-1 SHALL be clamped to pMAX_STEPS-1.
REQ-023 Step hit: the latched step source is active; level mode = input high; edge mode = input high and low on the previous cycle. The edge history register SHALL update every cycle in every state.
REQ-024 WAIT_FIRST: step-0 hit clears counter and sets step=1; go DONE if last_step=0, else WAIT_NEXT.
REQ-025 WAIT_NEXT: counter SHALL be 0 in the first cycle after the accepted trigger and increment by 1 per cycle, saturating at all-ones with no wrap.
REQ-026 WAIT_NEXT, hit with counter >= min_wait[step-1] (min_wait 0 = no minimum): final step -> DONE; otherwise clear counter, increment step.
REQ-027 WAIT_NEXT, hit with counter < min_wait[step-1]: set O_too_early and go IDLE.
REQ-028 WAIT_NEXT, no hit and counter == max_wait[step-1] (nonzero): set O_too_late and go IDLE. max_wait 0 = no timeout. A hit SHALL take priority over a timeout in the same cycle.
REQ-029 O_trigger SHALL be registered and high exactly one cycle, the cycle after entering DONE.
REQ-030 DONE: I_rearm=1 -> IDLE next cycle; I_rearm=0 -> hold DONE until armed_and_ready falls.
REQ-031 armed_and_ready low SHALL force IDLE next cycle from any state, setting no flags and suppressing any pending O_trigger.
REQ-032 I_bypass=1 SHALL drive O_trigger combinationally from I_trigger[I_step_source[0 +: SRCW]] (unlatched); the FSM still runs but its pulse is masked.
REQ-033 Sticky flags SHALL clear on I_clear_status; a set event in the same cycle SHALL win.
REQ-034 O_step SHALL read 0 in IDLE and WAIT_FIRST, the awaited step in WAIT_NEXT, and the last step in DONE.

Reset
REQ-035 Reset asserted SHALL immediately give state IDLE, counter 0, O_step 0, O_trigger 0, O_too_early 0, O_too_late 0, edge history 0, and latched config 0.
REQ-036 Reset deassertion mid-sequence SHALL resume from IDLE and restart only via REQ-021.

Verification
REQ-037 sources {0,2,1}, last_step=2, min={3,3}, max={10,10}; triggers spaced 5 cycles -> one O_trigger pulse 1 cycle after the 3rd trigger, no flags.
REQ-038 as REQ-037 but 2nd trigger 2 cycles after the 1st (counter=1 < 3) -> O_too_early=1, no O_trigger, restart in WAIT_FIRST 2 cycles later.
REQ-039 max={4,4}, no 2nd trigger -> O_too_late=1 once counter reaches 4; clear it with I_clear_status; set+clear in the same cycle -> flag stays 1.
REQ-040 edge mode, step 0 and step 1 on input 0, held high 20 cycles, min=0 -> no advance past step 1; level mode -> O_trigger 2 cycles after input rises.
REQ-041 I_rearm=0 after firing -> stays DONE, a 2nd sequence gives no pulse until armed_and_ready toggles; armed_and_ready dropped at step 2 -> IDLE, no flags.
REQ-042 min=0, max=0, 2nd trigger after 70000 cycles (W=16) -> counter saturates at 0xFFFF, no timeout, O_trigger fires.
